mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 26, which is the byte-array depth.
REQ-002 SHALL have parameter MAX_ADDR, default 17, which is the highest legal 64-bit access base address.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 f_req  input  1  fetch-port read request, held as a level until f_done.
REQ-007 f_addr  input  64  fetch byte base address.
REQ-008 f_done  output  1  one-cycle completion pulse for the fetch port.
REQ-009 f_rdata  output  64  fetch read data; valid while f_done=1.
REQ-010 f_error  output  1  fetch address error; valid while f_done=1.
REQ-011 d_req  input  1  data-port request, held as a level until d_done.
REQ-012 d_write  input  1  data-port direction: 1=write, 0=read.
REQ-013 d_addr  input  64  data byte base address.
REQ-014 d_wdata  input  64  data-port write data.
REQ-015 d_done, d_rdata, d_error  output  1/64/1  data-port equivalents of f_done, f_rdata and f_error.
REQ-016 mem_en  output  1  byte-memory access strobe.
REQ-017 mem_we  output  1  byte-memory write enable.
REQ-018 mem_addr  output  5  byte address.
REQ-019 mem_wdata  output  8  byte write data.
REQ-020 mem_rdata  input  8  byte read data, combinational from mem_addr.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, XFER and RESP.
REQ-023 In IDLE with at least one request active, the FSM SHALL grant one port, capture its address, direction and write data, and move to XFER (address legal) or RESP (address illegal).
REQ-024 Arbitration SHALL be round-robin on contention: grant the port not granted last; after reset, data has priority.
REQ-025 A lone request SHALL be granted regardless of history, and every grant SHALL update the last-grant record.
REQ-026 The captured address SHALL be legal iff addr <= MAX_ADDR; all 64 bits are compared, unsigned.
REQ-027 XFER SHALL last exactly 8 cycles with byte counter k=0..7 and mem_en=1, mem_addr=addr+k.
REQ-028 Byte order SHALL be big-endian: byte k maps to data bits [63-8k:56-8k].
REQ-029 For a write in XFER, mem_we SHALL be 1 and mem_wdata SHALL be the byte-k slice of the captured write data.
REQ-030 For a read in XFER, mem_we SHALL be 0 and mem_rdata SHALL be latched into byte k of the read register at the end of each XFER cycle.
REQ-031 After k=7 the FSM SHALL move to RESP.
REQ-032 RESP SHALL last one cycle with the granted port's done=1, error per REQ-026, and rdata=assembled word (0 on error or write); the FSM then returns to IDLE.
REQ-033 An illegal address SHALL produce zero mem_en cycles, done one cycle after grant, and error=1.
REQ-034 Latency SHALL be: request sampled at edge E, done high during cycle E+9 (legal) or E+1 (illegal).
REQ-035 A requester SHALL deassert req on the edge at which it samples done; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-036 Request inputs changing during XFER or RESP SHALL NOT affect the transfer in progress.
REQ-037 Outside XFER, mem_en and mem_we SHALL be 0.
REQ-038 Outside RESP, the done and error outputs of both ports SHALL be 0.
REQ-039 rdata outputs SHALL hold their value until the next RESP of the same port.
REQ-040 No request SHALL be dropped: a losing requester SHALL be served by the next grant.

Reset
REQ-041 rst_n=0 SHALL asynchronously force state IDLE, k=0 and last-grant=fetch (so data wins next).
REQ-042 rst_n=0 SHALL asynchronously force all outputs to 0.
REQ-043 Reset during XFER SHALL abort the access without a done pulse; bytes already written remain in memory.
REQ-044 The first grant SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-045 Data write: d_write=1, d_addr=4, d_wdata=64'h0102030405060708 -> mem_addr 4..11 carry bytes 01..08, d_done in cycle E+9, d_error=0.
REQ-046 Fetch read: preload 0xAA at address 4 and 0xB1..0xB7 at addresses 5..11; f_addr=4 -> f_rdata=64'hAAB1B2B3B4B5B6B7, f_error=0.
REQ-047 Illegal address: d_addr=18 -> no mem_en, d_done with d_error=1 and d_rdata=0 at E+1; d_addr=64'hFFFF_FFFF_FFFF_FFFF behaves identically.
REQ-048 Contention: f_req and d_req are raised together after reset and both held -> data served first, then fetch, then data again (round-robin).
REQ-049 Reset mid-op: drop rst_n at k=3 of a write -> mem_en=0 immediately, no d_done, busy=0, and only bytes 0..3 are written.
REQ-050 Back-to-back: fetch keeps f_req high one cycle past f_done -> a second fetch access starts, done 10 cycles after the first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its fetch/data requesters and the byte memory.
// Requests are held levels acknowledged by one-cycle done pulses; mem_rdata is combinational from mem_addr.
interface mem_arbiter_if;
   logic        f_req;
   logic [63:0] f_addr;
   logic        f_done;
   logic [63:0] f_rdata;
   logic        f_error;

   logic        d_req;
   logic        d_write;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_done;
   logic [63:0] d_rdata;
   logic        d_error;

   logic        mem_en;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic        busy;

   modport slave (
      input  f_req, f_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      output f_done, f_rdata, f_error, d_done, d_rdata, d_error,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      input  f_done, f_rdata, f_error, d_done, d_rdata, d_error,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin fetch/data arbiter moving 64-bit big-endian words over an 8-bit byte memory.
// Latency: done 9 cycles after grant (1 on illegal address); losers wait as held requests until the next grant.
module mem_arbiter #(
   parameter int          MEM_BYTES = 26,
   parameter logic [63:0] MAX_ADDR  = 64'd17
) (
   input logic         clk,
   input logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    k_q, k_d;
   logic          last_d_q, last_d_d;
   logic          gnt_d_q, gnt_d_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [63:0]   wdata_q, wdata_d;
   logic [63:0]   rd_q, rd_d;
   logic [63:0]   f_rdata_q, f_rdata_d;
   logic [63:0]   d_rdata_q, d_rdata_d;

   logic          pick_d;
   logic [63:0]   sel_addr;
   logic [5:0]    bsel;
   logic          mem_en, mem_we, f_done, d_done, f_error, d_error;

   // Byte k sits at bit offset 8*(7-k); for a 3-bit k that is just ~k shifted by 3.
   assign bsel = {~k_q, 3'b000};

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      last_d_d  = last_d_q;
      gnt_d_d   = gnt_d_q;
      we_d      = we_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      f_done    = 1'b0;
      d_done    = 1'b0;
      f_error   = 1'b0;
      d_error   = 1'b0;
      pick_d    = bus.d_req && (!bus.f_req || !last_d_q);
      sel_addr  = pick_d ? bus.d_addr : bus.f_addr;

      case (state_q)
         IDLE: begin
            if (bus.f_req || bus.d_req) begin
               gnt_d_d  = pick_d;
               last_d_d = pick_d;
               we_d     = pick_d && bus.d_write;
               wdata_d  = bus.d_wdata;
               addr_d   = sel_addr[AW-1:0];
               err_d    = sel_addr > MAX_ADDR;
               k_d      = 3'd0;
               rd_d     = 64'd0;
               state_d  = (sel_addr > MAX_ADDR) ? RESP : XFER;
            end
         end
         XFER: begin
            mem_en = 1'b1;
            mem_we = we_q;
            if (!we_q) begin
               rd_d[bsel +: 8] = bus.mem_rdata;
            end
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) begin
               state_d = RESP;
            end
         end
         RESP: begin
            f_done  = !gnt_d_q;
            d_done  = gnt_d_q;
            f_error = !gnt_d_q && err_q;
            d_error = gnt_d_q && err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Load the granted port's rdata register on entry to RESP so it is valid with done and holds afterwards.
      if (state_d == RESP && state_q != RESP) begin
         if (gnt_d_d) begin
            d_rdata_d = (err_d || we_d) ? 64'd0 : rd_d;
         end else begin
            f_rdata_d = (err_d || we_d) ? 64'd0 : rd_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= 3'd0;
         last_d_q  <= 1'b0;
         gnt_d_q   <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 64'd0;
         rd_q      <= 64'd0;
         f_rdata_q <= 64'd0;
         d_rdata_q <= 64'd0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         last_d_q  <= last_d_d;
         gnt_d_q   <= gnt_d_d;
         we_q      <= we_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = 5'(addr_q + AW'(k_q));
   assign bus.mem_wdata = wdata_q[bsel +: 8];
   assign bus.f_done    = f_done;
   assign bus.d_done    = d_done;
   assign bus.f_error   = f_error;
   assign bus.d_error   = d_error;
   assign bus.f_rdata   = f_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus reset, contention and back-to-back sequences.
module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [7:0] mem [0:25];

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we && bus.mem_addr < 5'd26) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   always_comb begin
      bus.mem_rdata = 8'h00;
      if (bus.mem_addr < 5'd26) bus.mem_rdata = mem[bus.mem_addr];
   end

   typedef struct {
      logic        is_d;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [12];
   logic [63:0] f_hold = 64'd0;
   logic [63:0] d_hold = 64'd0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input int base);
      logic [63:0] w;
      w = 64'd0;
      for (int j = 0; j < 8; j++) w = {w[55:0], mem[base + j]};
      return w;
   endfunction

   task automatic run_txn(input string nm, input vec_t v);
      int          cyc, men, t_done;
      logic        seq_ok, other_bad, got_err;
      logic [63:0] got_rd, other_rd;
      @(posedge clk); #1;
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_write = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wd;
      end else begin
         bus.f_req = 1'b1; bus.f_addr = v.addr;
      end
      @(posedge clk);
      cyc = 0; men = 0; t_done = 0; seq_ok = 1'b1; other_bad = 1'b0;
      got_err = 1'b0; got_rd = 64'd0; other_rd = 64'd0;
      while (t_done == 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_en) begin
            if (men > 7 || bus.mem_addr !== 5'(v.addr[4:0] + 5'(men)) || bus.mem_we !== v.wr ||
                (v.wr && bus.mem_wdata !== v.wd[63-8*men -: 8])) seq_ok = 1'b0;
            men++;
         end
         if (v.is_d ? bus.f_done : bus.d_done) other_bad = 1'b1;
         if (v.is_d ? bus.d_done : bus.f_done) begin
            t_done   = cyc;
            got_rd   = v.is_d ? bus.d_rdata : bus.f_rdata;
            got_err  = v.is_d ? bus.d_error : bus.f_error;
            other_rd = v.is_d ? bus.f_rdata : bus.d_rdata;
         end
      end
      @(posedge clk); #1;
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      chk({nm, "_latency"}, 64'(t_done), v.exp_err ? 64'd1 : 64'd9);
      chk({nm, "_error"}, 64'(got_err), 64'(v.exp_err));
      chk({nm, "_rdata"}, got_rd, v.exp_rd);
      chk({nm, "_mem_en_cycles"}, 64'(men), v.exp_err ? 64'd0 : 64'd8);
      chk({nm, "_byte_seq"}, 64'(seq_ok), 64'd1);
      chk({nm, "_other_done"}, 64'(other_bad), 64'd0);
      chk({nm, "_other_rdata_hold"}, other_rd, v.is_d ? f_hold : d_hold);
      if (v.is_d) d_hold = v.exp_rd; else f_hold = v.exp_rd;
      if (v.wr && !v.exp_err) chk({nm, "_mem_content"}, mem_word(int'(v.addr[4:0])), v.wd);
   endtask

   initial begin : main
      int          cyc, n, t1, t2, found;
      logic        ord [3];
      int          tt  [3];
      logic [63:0] rdv [3];
      logic        done_seen;
      logic [63:0] rd2;

      rst_n = 1'b1;
      bus.f_req = 1'b0; bus.f_addr = 64'd0;
      bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = 64'd0; bus.d_wdata = 64'd0;

      vecs[0]  = '{1'b1, 1'b1, 64'd0,  64'h0000000000000000, 64'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 64'd4,  64'h0102030405060708, 64'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 64'd4,  64'd0, 64'h0102030405060708, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 64'd4,  64'hAAB1B2B3B4B5B6B7, 64'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 64'd4,  64'd0, 64'hAAB1B2B3B4B5B6B7, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 64'd4,  64'd0, 64'hAAB1B2B3B4B5B6B7, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 64'd18, 64'd0, 64'd0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 64'd17, 64'h1122334455667788, 64'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 64'd17, 64'd0, 64'h1122334455667788, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 64'd18, 64'd0, 64'd0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 64'h0000_0001_0000_0004, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b1};

      #1 rst_n = 1'b0;
      #2;
      chk("reset_outputs", {54'd0, bus.f_done, bus.d_done, bus.f_error, bus.d_error,
                            bus.mem_en, bus.mem_we, bus.busy, 3'd0}, 64'd0);
      chk("reset_rdata", bus.f_rdata | bus.d_rdata, 64'd0);
      chk("reset_mem_bus", {51'd0, bus.mem_addr, bus.mem_wdata}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back fetch: request held through the IDLE cycle after done.
      @(posedge clk); #1;
      bus.f_req = 1'b1; bus.f_addr = 64'd4;
      @(posedge clk);
      cyc = 0; t1 = 0; t2 = 0; rd2 = 64'd0;
      while (t2 == 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.f_done) begin
            if (t1 == 0) t1 = cyc;
            else begin t2 = cyc; rd2 = bus.f_rdata; end
         end
         if (t1 != 0 && cyc == t1 + 2) bus.f_req = 1'b0;
      end
      chk("b2b_first_latency", 64'(t1), 64'd9);
      chk("b2b_gap", 64'(t2 - t1), 64'd10);
      chk("b2b_second_rdata", rd2, 64'hAAB1B2B3B4B5B6B7);
      @(posedge clk); #1;
      bus.f_req = 1'b0;

      // Reset in the middle of a data write: bytes 0..3 land, the rest must not.
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 64'd0; bus.d_wdata = 64'hC0C1C2C3C4C5C6C7;
      found = 0; cyc = 0;
      while (found == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_en && bus.mem_addr == 5'd3) found = 1;
      end
      chk("rst_mid_reached_k3", 64'(found), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_f_rdata_cleared", bus.f_rdata, 64'd0);
      bus.d_req = 1'b0;
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.d_done || bus.f_done) done_seen = 1'b1;
      end
      chk("rst_mid_no_done", 64'(done_seen), 64'd0);
      chk("rst_mid_mem_bytes", mem_word(0), 64'hC0C1C2C3AAB1B2B3);

      // Contention straight out of reset: data, fetch, data.
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 64'd0;
      bus.f_req = 1'b1; bus.f_addr = 64'd4;
      @(posedge clk);
      cyc = 0; n = 0;
      for (int j = 0; j < 3; j++) begin ord[j] = 1'b0; tt[j] = 0; rdv[j] = 64'd0; end
      while (n < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.d_done || bus.f_done) begin
            ord[n] = bus.d_done;
            tt[n]  = cyc;
            rdv[n] = bus.d_done ? bus.d_rdata : bus.f_rdata;
            n++;
         end
      end
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      bus.f_req = 1'b0;
      chk("cont_count", 64'(n), 64'd3);
      chk("cont_order", {61'd0, ord[0], ord[1], ord[2]}, 64'b101);
      chk("cont_t0", 64'(tt[0]), 64'd9);
      chk("cont_t1", 64'(tt[1]), 64'd19);
      chk("cont_t2", 64'(tt[2]), 64'd29);
      chk("cont_d_rdata", rdv[0], 64'hC0C1C2C3AAB1B2B3);
      chk("cont_f_rdata", rdv[1], 64'hAAB1B2B3B4B5B6B7);
      chk("cont_d_rdata2", rdv[2], 64'hC0C1C2C3AAB1B2B3);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
